tpu_host_driver: RTL and testbench

Host-side driver for the TPU pin interface: the transmitting and receiving end opposite the TPU top-level. It buffers 16-bit instruction words from a host and drives them onto the TPU's 8+8 input pins, one word per cycle. For every STORE it captures the byte the TPU returns on its 8 output pins and delivers it to the host through a ready/valid response stream. It is used in FPGA bring-up and at system level in place of a hand-driven pin sequence.

---
 rtl/tpu_pkg.sv | 15 +
 rtl/sync_fifo.sv | 44 ++++
 rtl/tpu_host_driver.sv | 80 ++++++++
 tb/tb_tpu_host_driver.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared instruction-word layout, opcodes and driver FSM states
package tpu_pkg;
    localparam int WORD_W = 16;
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 14;
    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_LOAD    = 2'b01;
    localparam logic [1:0] OP_STORE   = 2'b10;
    localparam logic [1:0] OP_COMPUTE = 2'b11;
    localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;
    typedef enum logic {IDLE, WAIT_RD} drv_state_e;
    function automatic logic [1:0] opcode(input logic [WORD_W-1:0] w);
        return w[OP_MSB:OP_LSB];
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with occupancy count; reads zero when empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    always_comb begin
        do_push = push && (cnt_q < FULL);
        do_pop  = pop && (cnt_q != '0);
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = wdata;
        wr_d  = do_push ? wr_q + 1'b1 : wr_q;
        rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    assign rdata = (cnt_q == '0) ? '0 : mem_q[rd_q];
    assign count = cnt_q;
endmodule

// File: rtl/tpu_host_driver.sv
// tpu_host_driver: issues buffered instruction words to the TPU pins and returns STORE bytes
module tpu_host_driver
    import tpu_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [7:0]  tpu_ui,
    output logic [7:0]  tpu_uio,
    input  logic [7:0]  tpu_uo,
    output logic        busy
);
    localparam int CW = $clog2(CMD_DEPTH);
    localparam logic [CW:0] CMD_FULL = CMD_DEPTH[CW:0];
    drv_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [WORD_W-1:0] pin_q, pin_d, cmd_head;
    logic [CW:0] cmd_count;
    logic [1:0] rsp_count, credits;
    logic cmd_pop, rsp_push;
    sync_fifo #(.WIDTH(WORD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk(clk), .rst(rst), .push(cmd_valid && cmd_ready), .wdata(cmd_data),
        .pop(cmd_pop), .rdata(cmd_head), .count(cmd_count)
    );
    sync_fifo #(.WIDTH(8), .DEPTH(2)) u_rsp_fifo (
        .clk(clk), .rst(rst), .push(rsp_push), .wdata(tpu_uo),
        .pop(rsp_ready), .rdata(rsp_data), .count(rsp_count)
    );
    assign cmd_ready = cmd_count < CMD_FULL;
    assign rsp_valid = rsp_count != 2'd0;
    // a STORE may only issue when its result is guaranteed a response slot
    assign credits = rsp_count + {1'b0, state_q == WAIT_RD};
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pin_d    = NOP_WORD;
        cmd_pop  = 1'b0;
        rsp_push = 1'b0;
        if (state_q == WAIT_RD) begin
            if (cnt_q == 3'd0) begin
                rsp_push = 1'b1;
                state_d  = IDLE;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end else if (cmd_count != '0) begin
            if (opcode(cmd_head) != OP_STORE) begin
                cmd_pop = 1'b1;
                pin_d   = cmd_head;
            end else if (credits < 2'd2) begin
                cmd_pop = 1'b1;
                pin_d   = cmd_head;
                cnt_d   = RD_LAT[2:0];
                state_d = WAIT_RD;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            pin_q   <= NOP_WORD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pin_q   <= pin_d;
        end
    end
    assign tpu_ui  = pin_q[7:0];
    assign tpu_uio = pin_q[15:8];
    assign busy    = (cmd_count != '0) || (state_q == WAIT_RD) || (pin_q != NOP_WORD);
endmodule

// File: tb/tb_tpu_host_driver.sv
// tb_tpu_host_driver: directed checks of issue timing, STORE returns, backpressure and reset
module tb_tpu_host_driver;
    logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic [15:0] cmd_data = 16'h0;
    logic cmd_ready, rsp_valid, busy;
    logic [7:0] rsp_data, tpu_ui, tpu_uio, tpu_uo;
    logic [15:0] pins;
    logic [15:0] p1 = 16'h0, p2 = 16'h0, p3 = 16'h0;
    logic [15:0] seen[$];
    logic [7:0] rq[$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    tpu_host_driver #(.CMD_DEPTH(4), .RD_LAT(3)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .tpu_ui(tpu_ui), .tpu_uio(tpu_uio), .tpu_uo(tpu_uo),
        .busy(busy)
    );

    assign pins = {tpu_uio, tpu_ui};
    // TPU stand-in: a STORE seen on the pins in cycle C returns low byte ^ 0xA0 in cycle C+3 only
    assign tpu_uo = (p3[15:14] == 2'b10) ? (p3[7:0] ^ 8'hA0) : 8'h00;

    always @(posedge clk) begin
        p1 <= pins;
        p2 <= p1;
        p3 <= p2;
        if (pins != 16'h0) seen.push_back(pins);
        if (!rst && rsp_valid && rsp_ready) rq.push_back(rsp_data);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b1; cmd_data = 16'h4012;
        tick; tick;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0h exp 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0h exp 0", rsp_valid); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %0h exp 00", rsp_data); end
        checks++; if (pins !== 16'h0000) begin errors++; $display("FAIL reset_pins got %0h exp 0000", pins); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
        rst = 1'b0; cmd_valid = 1'b0;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %0h exp 0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_cmd_ready got %0h exp 1", cmd_ready); end
        tick;
        checks++; if (pins !== 16'h0000) begin errors++; $display("FAIL post_reset_pins got %0h exp 0000", pins); end
    endtask

    task automatic test_back_to_back;
        cmd_valid = 1'b1; cmd_data = 16'h4012;
        tick;
        cmd_data = 16'hC000;
        tick;
        checks++; if (pins !== 16'h4012) begin errors++; $display("FAIL b2b_word0 got %0h exp 4012", pins); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %0h exp 1", busy); end
        cmd_data = 16'h4034;
        tick;
        checks++; if (pins !== 16'hC000) begin errors++; $display("FAIL b2b_word1 got %0h exp c000", pins); end
        cmd_valid = 1'b0;
        tick;
        checks++; if (pins !== 16'h4034) begin errors++; $display("FAIL b2b_word2 got %0h exp 4034", pins); end
        tick;
        checks++; if (pins !== 16'h0000) begin errors++; $display("FAIL b2b_nop got %0h exp 0000", pins); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_fall got %0h exp 0", busy); end
    endtask

    task automatic test_store;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_data = 16'h8005;
        tick;
        cmd_valid = 1'b0;
        tick;
        checks++; if (pins !== 16'h8005) begin errors++; $display("FAIL store_pins got %0h exp 8005", pins); end
        for (int i = 1; i <= 3; i++) begin
            tick;
            checks++; if (pins !== 16'h0000) begin errors++; $display("FAIL store_gap_c%0d got %0h exp 0000", i, pins); end
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL store_early_c%0d got %0h exp 0", i, rsp_valid); end
        end
        tick;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL store_rsp_valid got %0h exp 1", rsp_valid); end
        checks++; if (rsp_data !== 8'hA5) begin errors++; $display("FAIL store_rsp_data got %0h exp a5", rsp_data); end
        tick;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL store_rsp_popped got %0h exp 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL store_busy got %0h exp 0", busy); end
    endtask

    task automatic test_backpressure;
        logic issued;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_data = 16'h80B1; tick;
        cmd_data = 16'h8082; tick;
        cmd_data = 16'h8093; tick;
        cmd_valid = 1'b0;
        issued = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (pins == 16'h8093) issued = 1'b1;
        end
        checks++; if (issued !== 1'b0) begin errors++; $display("FAIL bp_third_blocked got %0h exp 0", issued); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid got %0h exp 1", rsp_valid); end
        checks++; if (rsp_data !== 8'h11) begin errors++; $display("FAIL bp_head0 got %0h exp 11", rsp_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy got %0h exp 1", busy); end
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
        checks++; if (rsp_data !== 8'h22) begin errors++; $display("FAIL bp_head1 got %0h exp 22", rsp_data); end
        issued = 1'b0;
        for (int i = 0; i < 10 && !issued; i++) begin
            tick;
            if (pins == 16'h8093) issued = 1'b1;
        end
        checks++; if (issued !== 1'b1) begin errors++; $display("FAIL bp_third_issue got %0h exp 1", issued); end
        for (int i = 0; i < 5; i++) tick;
        checks++; if (rsp_data !== 8'h22) begin errors++; $display("FAIL bp_head1_held got %0h exp 22", rsp_data); end
        rsp_ready = 1'b1; tick;
        checks++; if (rsp_data !== 8'h33) begin errors++; $display("FAIL bp_head2 got %0h exp 33", rsp_data); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_head2_valid got %0h exp 1", rsp_valid); end
        tick;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %0h exp 0", rsp_valid); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_full;
        logic [15:0] exp_pins [5];
        logic [7:0] exp_rsp [3];
        logic ok;
        exp_pins[0] = 16'h8083; exp_pins[1] = 16'h4001; exp_pins[2] = 16'h4002;
        exp_pins[3] = 16'h4003; exp_pins[4] = 16'h4004;
        exp_rsp[0] = 8'h21; exp_rsp[1] = 8'h22; exp_rsp[2] = 8'h23;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_data = 16'h8081; tick;
        cmd_data = 16'h8082; tick;
        cmd_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick;
        seen.delete();
        rq.delete();
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_data = exp_pins[i];
            tick;
        end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low got %0h exp 0", cmd_ready); end
        cmd_data = 16'h4004;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_hold%0d got %0h exp 0", i, cmd_ready); end
        end
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (cmd_ready) ok = 1'b1;
            tick;
        end
        cmd_valid = 1'b0;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_fifth_accept got %0h exp 1", ok); end
        rsp_ready = 1'b1;
        for (int i = 0; i < 60 && busy; i++) tick;
        for (int i = 0; i < 5; i++) tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_idle got %0h exp 0", busy); end
        checks++; if (seen.size() != 5) begin errors++; $display("FAIL full_issue_count got %0d exp 5", seen.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (((i < seen.size()) ? seen[i] : 16'hxxxx) !== exp_pins[i]) begin
                errors++; $display("FAIL full_issue%0d got %0h exp %0h", i, (i < seen.size()) ? seen[i] : 16'hxxxx, exp_pins[i]);
            end
        end
        checks++; if (rq.size() != 3) begin errors++; $display("FAIL full_rsp_count got %0d exp 3", rq.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (((i < rq.size()) ? rq[i] : 8'hxx) !== exp_rsp[i]) begin
                errors++; $display("FAIL full_rsp%0d got %0h exp %0h", i, (i < rq.size()) ? rq[i] : 8'hxx, exp_rsp[i]);
            end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_wait;
        rsp_ready = 1'b1;
        rq.delete();
        cmd_valid = 1'b1; cmd_data = 16'h8005;
        tick;
        cmd_valid = 1'b0;
        tick;
        checks++; if (pins !== 16'h8005) begin errors++; $display("FAIL rw_store_pins got %0h exp 8005", pins); end
        tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if (pins !== 16'h0000) begin errors++; $display("FAIL rw_pins got %0h exp 0000", pins); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rw_busy got %0h exp 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rw_rsp_valid got %0h exp 0", rsp_valid); end
        for (int i = 0; i < 6; i++) tick;
        checks++; if (rq.size() != 0) begin errors++; $display("FAIL rw_no_response got %0d exp 0", rq.size()); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rw_rsp_late got %0h exp 0", rsp_valid); end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_store;
        test_backpressure;
        test_full;
        test_reset_wait;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
